// File: rtl/booth_mult_seq.sv
// Sequential signed WIDTH x WIDTH Booth multiplier producing a split hi/lo product.
// Radix-2 recoding by default; define BOOTH_RADIX4_EN for radix-4 (modified Booth) recoding.
module booth_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef BOOTH_RADIX4_EN
   // Two guard bits so that +/-2M added to a sign-extended accumulator cannot wrap.
   localparam int ACC_W = WIDTH + 2;
   localparam int STEPS = WIDTH / 2;
`else
   // One guard bit keeps -M exact for M = -2^(WIDTH-1).
   localparam int ACC_W = WIDTH + 1;
   localparam int STEPS = WIDTH;
`endif

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] counter;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_1;
   logic [ACC_W-1:0] acc;

   logic [ACC_W-1:0] m_ext;
   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] acc_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             q1_nxt;

   // One Booth step: recode the low multiplier bits, add the selected multiple of M,
   // then arithmetic-shift {acc, q_reg, q_1} right by the radix width.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      m_ext   = {{(ACC_W - WIDTH){m_reg[WIDTH-1]}}, m_reg};
      addend  = '0;
      sum     = '0;
      acc_nxt = acc;
      q_nxt   = q_reg;
      q1_nxt  = q_1;
`ifdef BOOTH_RADIX4_EN
      case ({q_reg[1:0], q_1})
         3'b001, 3'b010: addend = m_ext;
         3'b011:         addend = m_ext << 1;
         3'b100:         addend = -(m_ext << 1);
         3'b101, 3'b110: addend = -m_ext;
         default:        addend = '0;
      endcase
      sum     = acc + addend;
      acc_nxt = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
      q_nxt   = {sum[1:0], q_reg[WIDTH-1:2]};
      q1_nxt  = q_reg[1];
`else
      case ({q_reg[0], q_1})
         2'b01:   addend = m_ext;
         2'b10:   addend = -m_ext;
         default: addend = '0;
      endcase
      sum     = acc + addend;
      acc_nxt = {sum[ACC_W-1], sum[ACC_W-1:1]};
      q_nxt   = {sum[0], q_reg[WIDTH-1:1]};
      q1_nxt  = q_reg[0];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         counter <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         q_1     <= 1'b0;
         acc     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  m_reg   <= mcand;
                  q_reg   <= mplier;
                  q_1     <= 1'b0;
                  acc     <= '0;
                  counter <= CNT_INIT;
                  busy    <= 1'b1;
               end
            end
            S_RUN: begin
               if (counter != '0) begin
                  acc     <= acc_nxt;
                  q_reg   <= q_nxt;
                  q_1     <= q1_nxt;
                  counter <= counter - CNT_W'(1);
               end else begin
                  // The product is {acc[WIDTH-1:0], q_reg}; upper acc bits are pure sign extension.
                  state <= S_DONE;
                  hi    <= acc[WIDTH-1:0];
                  lo    <= q_reg;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
